// File: rtl/pe_skew_feeder_pkg.sv
// pe_feeder_pkg: state encoding and default widths shared by the pe_skew_feeder slice.
package pe_feeder_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} feeder_state_e;
   localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/pe_skew_feeder_if.sv
// pe_skew_feeder_if: valid/ready beat bus carrying LANES packed activation/weight pairs.
interface pe_skew_feeder_if import pe_feeder_pkg::*; #(
   parameter int LANES  = 4,
   parameter int DATA_W = DATA_W_DEF
);
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_last;
   logic [LANES*DATA_W-1:0] s_a;
   logic [LANES*DATA_W-1:0] s_b;
   modport master (output s_valid, s_a, s_b, s_last, input s_ready);
   modport slave  (input s_valid, s_a, s_b, s_last, output s_ready);
endinterface

// File: rtl/pe_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register of {en, data}; stage 0 data loads only on en,
// so bubble slots carry the most recent real beat down the line.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic         o_en,
   output logic [W-1:0] o_d
);
   logic         r_en [DEPTH];
   logic [W-1:0] r_d  [DEPTH];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_en[k] <= 1'b0;
            r_d[k]  <= '0;
         end
      end else begin
         r_en[0] <= i_en;
         if (i_en) r_d[0] <= i_d;
         for (int k = 1; k < DEPTH; k++) begin
            r_en[k] <= r_en[k-1];
            r_d[k]  <= r_d[k-1];
         end
      end
   assign o_en = r_en[DEPTH-1];
   assign o_d  = r_d[DEPTH-1];
endmodule

// File: rtl/pe_skew_feeder.sv
// pe_skew_feeder: tile FSM plus per-lane skew delay lines feeding the PE array.
// Define PE_SKEW_FEEDER_ZERO_GATE_EN to force lane data to 0 whenever that lane's en is low.
module pe_skew_feeder import pe_feeder_pkg::*; #(
   parameter int LANES  = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   pe_skew_feeder_if.slave         s,
   output logic [LANES*DATA_W-1:0] a_lane,
   output logic [LANES*DATA_W-1:0] b_lane,
   output logic [LANES-1:0]        en_lane,
   output logic                    clr_out,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        beat_count
);
   localparam int DC_W = $clog2(LANES) + 1;
   feeder_state_e    r_state;
   logic             r_ready;
   logic             r_clr;
   logic             r_busy;
   logic             r_done;
   logic [DC_W-1:0]  r_drain;
   logic [CNT_W-1:0] r_cnt;
   logic             w_acc;
   assign w_acc = s.s_valid && r_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_clr   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drain <= '0;
         r_cnt   <= '0;
      end else begin
         r_clr  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE:
               if (start) begin
                  r_state <= CLEAR;
                  r_clr   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            CLEAR: begin
               r_state <= STREAM;
               r_ready <= 1'b1;
            end
            STREAM:
               if (w_acc) begin
                  if (~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
                  if (s.s_last) begin
                     r_state <= DRAIN;
                     r_ready <= 1'b0;
                     r_drain <= '0;
                  end
               end
            DRAIN:
               // last beat leaves lane LANES-1 on the final drain cycle
               if (r_drain == DC_W'(LANES - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else r_drain <= r_drain + DC_W'(1);
            default: r_state <= IDLE;
         endcase
      end
   assign s.s_ready  = r_ready;
   assign clr_out    = r_clr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign beat_count = r_cnt;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic                w_en;
      logic [2*DATA_W-1:0] w_d;
      skew_delay_line #(.DEPTH(i + 1), .W(2 * DATA_W)) u_dl (
         .clk,
         .rst_n,
         .i_en (w_acc),
         .i_d  ({s.s_a[i*DATA_W +: DATA_W], s.s_b[i*DATA_W +: DATA_W]}),
         .o_en (w_en),
         .o_d  (w_d)
      );
      assign en_lane[i] = w_en;
`ifdef PE_SKEW_FEEDER_ZERO_GATE_EN
      assign {a_lane[i*DATA_W +: DATA_W], b_lane[i*DATA_W +: DATA_W]} = w_en ? w_d : '0;
`else
      assign {a_lane[i*DATA_W +: DATA_W], b_lane[i*DATA_W +: DATA_W]} = w_d;
`endif
   end
endmodule

// File: tb/tb_pe_skew_feeder.sv
// tb_pe_skew_feeder: directed tiles checked per cycle against a beat-history model of the skewed lanes.
module tb_pe_skew_feeder;
   import pe_feeder_pkg::*;
   localparam int LANES = 4, DW = 8, CW = 16, N = 4096;
   logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0, tb_acc = 1'b0;
   logic [LANES*DW-1:0]   a_lane, b_lane;
   logic [LANES-1:0]      en_lane;
   logic                  clr_out, busy, done;
   logic [CW-1:0]         beat_count;
   int                    checks = 0, errors = 0, cyc = 0, done_cnt = 0;
   bit                    hv [N], hl [N], hr [N];
   logic [LANES*DW-1:0]   ha [N], hb [N];
   logic [LANES*DW-1:0]   ta [8], tbv [8];
   logic                  e0 [32], e3 [32];
   logic [DW-1:0]         a0h [32];

   pe_skew_feeder_if #(.LANES(LANES), .DATA_W(DW)) s_if ();

   pe_skew_feeder #(.LANES(LANES), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s          (s_if),
      .a_lane     (a_lane),
      .b_lane     (b_lane),
      .en_lane    (en_lane),
      .clr_out    (clr_out),
      .busy       (busy),
      .done       (done),
      .beat_count (beat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // last beat accepted at or before cycle s since the most recent reset; 0 if none
   function automatic logic [DW-1:0] held(input int s, input int i, input bit isa);
      for (int k = s; k >= 0; k--) begin
         if (hr[k]) return '0;
         if (hv[k]) return isa ? ha[k][i*DW +: DW] : hb[k][i*DW +: DW];
      end
      return '0;
   endfunction

   function automatic bit clean(input int s, input int c);
      for (int k = s; k <= c; k++) if (hr[k]) return 1'b0;
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      logic [LANES*DW-1:0] ea, eb;
      logic [LANES-1:0]    ee;
      logic                ed;
      int                  sd;
      hv[cyc] = tb_acc;
      hl[cyc] = tb_acc && s_if.s_last;
      hr[cyc] = !rst_n;
      ha[cyc] = s_if.s_a;
      hb[cyc] = s_if.s_b;
      for (int i = 0; i < LANES; i++) begin
         int  s;
         bit  ok;
         s  = cyc - 1 - i;
         ok = s >= 0 && clean(s, cyc);
         ee[i] = ok && hv[s];
`ifdef PE_SKEW_FEEDER_ZERO_GATE_EN
         ea[i*DW +: DW] = ee[i] ? held(s, i, 1'b1) : '0;
         eb[i*DW +: DW] = ee[i] ? held(s, i, 1'b0) : '0;
`else
         ea[i*DW +: DW] = ok ? held(s, i, 1'b1) : '0;
         eb[i*DW +: DW] = ok ? held(s, i, 1'b0) : '0;
`endif
      end
      sd = cyc - 1 - LANES;
      ed = sd >= 0 && clean(sd, cyc) && hl[sd];
      chk("lane_en", en_lane, ee);
      chk("lane_a", a_lane, ea);
      chk("lane_b", b_lane, eb);
      chk("done", done, ed);
      if (done === 1'b1) done_cnt++;
      if (cyc < N - 1) cyc++;
   end

   task automatic drive(input logic v, input logic acc, input logic last, input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b);
      s_if.s_valid = v;
      tb_acc       = acc;
      s_if.s_last  = last;
      s_if.s_a     = a;
      s_if.s_b     = b;
   endtask

   task automatic rec(inout int k);
      k++;
      if (k < 32) begin
         e0[k]  = en_lane[0];
         e3[k]  = en_lane[LANES-1];
         a0h[k] = a_lane[DW-1:0];
      end
   endtask

   task automatic run_tile(input int nb, input int gap, input bit mid, input int abort_j);
      int k, d0;
      d0 = done_cnt;
      tick();
      start = 1'b1;
      chk("idle_busy", busy, 0);
      tick();
      start = 1'b0;
      chk("clr_pulse", clr_out, 1);
      chk("clr_ready", s_if.s_ready, 0);
      chk("clr_busy", busy, 1);
      chk("clr_cnt", beat_count, 0);
      k = -1;
      for (int n = 0; n < nb; n++) begin
         tick();
         rec(k);
         chk("stream_ready", s_if.s_ready, 1);
         chk("stream_clr", clr_out, 0);
         chk("stream_cnt", beat_count, n);
         drive(1'b1, 1'b1, n == nb - 1, ta[n], tbv[n]);
         start = mid && n == 1;
         if (n == gap) begin
            tick();
            rec(k);
            chk("gap_ready", s_if.s_ready, 1);
            start = 1'b0;
            drive(1'b0, 1'b0, 1'b1, $urandom, $urandom);
         end
      end
      for (int j = 1; j <= LANES; j++) begin
         tick();
         rec(k);
         start = 1'b0;
         drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
         if (j == abort_j) begin
            rst_n = 1'b0;
            #1;
            chk("abort_en", en_lane, 0);
            chk("abort_a", a_lane, 0);
            chk("abort_b", b_lane, 0);
            chk("abort_busy", busy, 0);
            chk("abort_cnt", beat_count, 0);
            chk("abort_ready", s_if.s_ready, 0);
            tick();
            tick();
            rst_n = 1'b1;
            repeat (LANES + 2) tick();
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_idle", busy, 0);
            return;
         end
         chk("drain_ready", s_if.s_ready, 0);
         chk("drain_busy", busy, 1);
         chk("drain_clr", clr_out, 0);
         chk("drain_cnt", beat_count, nb);
         chk("drain_en", en_lane[j-1], 1);
         chk("drain_a", a_lane[(j-1)*DW +: DW], ta[nb-1][(j-1)*DW +: DW]);
         chk("drain_b", b_lane[(j-1)*DW +: DW], tbv[nb-1][(j-1)*DW +: DW]);
      end
      tick();
      rec(k);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_cnt", beat_count, nb);
      tick();
      chk("done_low", done, 0);
      chk("done_once", done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_en", en_lane, 0);
      chk("rst_a", a_lane, 0);
      chk("rst_ready", s_if.s_ready, 0);
      chk("rst_clr", clr_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", beat_count, 0);
      drive(1'b1, 1'b0, 1'b1, 32'h11223344, 32'h55667788);
      repeat (3) begin
         tick();
         chk("idle_ready", s_if.s_ready, 0);
         chk("idle_cnt", beat_count, 0);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("idle_no_en", en_lane, 0);

      ta[0]  = {8'd4, 8'd3, 8'd2, 8'd1};
      tbv[0] = {8'hFD, 8'h07, 8'h05, 8'h02};
      run_tile(1, -1, 1'b0, 0);

      ta[0] = 32'h0A0B0C0D; tbv[0] = 32'h80FF7F01;
      ta[1] = 32'h1A1B1C1D; tbv[1] = 32'hF0E0D0C0;
      ta[2] = 32'h2A2B2C2D; tbv[2] = 32'h00010203;
      run_tile(3, 1, 1'b0, 0);
      chk("en0_pattern", {e0[1], e0[2], e0[3], e0[4]}, 4'b1101);
      chk("en3_pattern", {e3[4], e3[5], e3[6], e3[7]}, 4'b1101);
`ifdef PE_SKEW_FEEDER_ZERO_GATE_EN
      chk("bubble_a0", a0h[3], 8'h00);
`else
      chk("bubble_a0", a0h[3], 8'h1D);
`endif

      ta[0] = 32'h7F80FE01; tbv[0] = 32'h12345678;
      ta[1] = 32'h99AABBCC; tbv[1] = 32'hDEADBEEF;
      ta[2] = 32'h01020304; tbv[2] = 32'hFFFFFFFF;
      run_tile(3, -1, 1'b1, 0);

      ta[0] = 32'hC0C1C2C3; tbv[0] = 32'hD0D1D2D3;
      ta[1] = 32'hE0E1E2E3; tbv[1] = 32'hF0F1F2F3;
      run_tile(2, -1, 1'b0, 2);

      ta[0] = 32'h80808080; tbv[0] = 32'h7F7F7F7F;
      ta[1] = 32'h00000000; tbv[1] = 32'hFFFFFFFF;
      ta[2] = 32'h5A5A5A5A; tbv[2] = 32'hA5A5A5A5;
      ta[3] = 32'h01FF02FE; tbv[3] = 32'h03FD04FC;
      run_tile(4, 2, 1'b0, 0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pe_skew_feeder.md
Name: pe_skew_feeder

Overview:
- Upstream stage of the PE systolic array.
- Accepts one beat per cycle: a vector of LANES signed int8 activation/weight pairs over a valid/ready handshake.
- Emits skewed per-lane streams: lane i delayed i cycles relative to lane 0, with matching per-lane en and a one-cycle array-wide clr at tile start.
- After the last beat it drains the skew pipeline and pulses done, so downstream acc values are final.

Parameters:
- LANES, 4, number of PE lanes fed (>=1).
- DATA_W, 8, element width in bits (signed).
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a tile (ignored unless IDLE)
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat ready
- s_a  in  LANES*DATA_W  activation vector, lane i at [i*DATA_W +: DATA_W]
- s_b  in  LANES*DATA_W  weight vector, same packing
- s_last  in  1  marks final beat of tile
- a_lane  out  LANES*DATA_W  skewed activations to PE a_in
- b_lane  out  LANES*DATA_W  skewed weights to PE b_in
- en_lane  out  LANES  per-lane PE enable
- clr_out  out  1  PE accumulator clear
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of drain
- beat_count  out  CNT_W  beats accepted in current/last tile

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - All delay-line data and en registers 0.
  - s_ready=0, clr_out=0, busy=0, done=0, beat_count=0.
  - Reset mid-tile aborts the tile immediately; no done pulse.
- States: IDLE, CLEAR, STREAM, DRAIN.
- IDLE:
  - s_ready=0.
  - start=1 -> CLEAR; beat_count<=0.
  - Beats presented in IDLE are not accepted.
- CLEAR: lasts exactly 1 cycle; clr_out=1 (registered output, asserted during the CLEAR cycle); s_ready=0; -> STREAM.
- STREAM:
  - s_ready=1. Accept when s_valid && s_ready; beat_count increments, saturating at all-ones.
  - Accepted beat at edge t: lane i presents element i on a_lane/b_lane with en_lane[i]=1 during cycle t+1+i.
  - Latency: lane 0 is 1 cycle; lane LANES-1 is LANES cycles.
  - A cycle with no accepted beat injects a bubble: en_lane[i]=0 in the corresponding skewed cycle.
  - Accepted beat with s_last=1 -> DRAIN, drain counter=0.
- DRAIN:
  - s_ready=0; bubbles injected.
  - Lasts LANES cycles, so the last beat exits lane LANES-1 on the final DRAIN cycle.
  - On exit, done=1 for 1 cycle (the cycle after the last lane's en); -> IDLE.
- start while busy: ignored.
- s_last with zero prior beats is legal: a 1-beat tile.
- Data while en_lane[i]=0: holds the last shifted value (stale) unless the optional feature is enabled.
- No arithmetic on data; bit-exact pass-through, signedness preserved.

Optional Feature:
- Macro: PE_SKEW_FEEDER_ZERO_GATE_EN.
- Defined: a_lane/b_lane lane i forced to 0 whenever en_lane[i]=0 (power/debug determinism; a PE with en=0 sees zeros).
- Undefined: bubble slots carry whatever propagated through the delay line. Timing and en are identical in both cases.

Decomposition:
- Package pe_feeder_pkg:
  - feeder_state_e enum {IDLE, CLEAR, STREAM, DRAIN}
  - localparam DATA_W_DEF=8
- Sub-module skew_delay_line:
  - Parameters DEPTH, W.
  - Async active-low reset shift register carrying {en, a, b}.
  - Instantiated per lane with DEPTH=i+1 via generate.
- The top holds the FSM, drain counter and beat counter.

Test Plan:
- Reset/idle: hold rst_n=0 five cycles, then release -> all outputs 0; start with no beats accepted leaves s_ready=0 in IDLE.
- Clear then skew:
  - start, then one beat a={4,3,2,1}, b={-3,7,5,2} (lane3..lane0) with s_last=1.
  - clr_out=1 in the cycle after start.
  - Lane 0 shows (1,2) en=1 at +1; lane 3 shows (4,-3) en=1 at +4.
  - done at +5; beat_count=1.
- Streaming with bubble:
  - 3 beats, with s_valid deasserted one cycle between beats 2 and 3.
  - en_lane[0] pattern 1,1,0,1.
  - en_lane[3] shows the same pattern shifted by 3.
  - beat_count=3.
- Ignored start: start pulsed during STREAM -> no second clr_out, state unchanged, done exactly once.
- Reset mid-tile: rst_n low during DRAIN -> outputs 0 immediately (async), no done; a new tile afterwards behaves normally.
- Zero gate: with PE_SKEW_FEEDER_ZERO_GATE_EN, bubble cycles show a_lane=b_lane=0; without it, the prior values are held.
